// File: rtl/mem_write_cmd_splitter_pkg.sv
// Shared field layout and descriptor types for the
// write command splitter.
package mem_write_cmd_splitter_pkg;

  localparam int ADDR_LSB = 0;
  localparam int LEN_LSB  = 64;
  localparam int ADDR_W   = 64;
  localparam int LEN_W    = 32;
  localparam int CMD_W    = 96;
  localparam int DATA_W   = 512;
  localparam int KEEP_W   = DATA_W / 8;
  localparam int BEATS_W  = 27;

  typedef struct packed {
    logic [BEATS_W-1:0] beats;
  } desc_t;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_t;

endpackage

// File: rtl/mem_write_cmd_splitter_fifo.sv
// Show-ahead descriptor FIFO linking the command
// splitter to the data beat counter.
module sync_desc_fifo
  import mem_write_cmd_splitter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  desc_t wdata,
  input  logic  pop,
  output desc_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  desc_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pop frees a slot first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_write_cmd_splitter.sv
// Splits write commands at CHUNK_BYTES boundaries and
// regenerates TLAST on the payload for each chunk.
module mem_write_cmd_splitter
  import mem_write_cmd_splitter_pkg::*;
#(
  parameter int CHUNK_BYTES = 4096,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [CMD_W-1:0]  s_axis_wr_cmd_TDATA,
  input  logic              s_axis_wr_cmd_TVALID,
  output logic              s_axis_wr_cmd_TREADY,
  output logic [CMD_W-1:0]  m_axis_wr_cmd_TDATA,
  output logic              m_axis_wr_cmd_TVALID,
  input  logic              m_axis_wr_cmd_TREADY,
  input  logic [DATA_W-1:0] s_axis_wr_data_TDATA,
  input  logic [KEEP_W-1:0] s_axis_wr_data_TKEEP,
  input  logic              s_axis_wr_data_TVALID,
  output logic              s_axis_wr_data_TREADY,
  output logic [DATA_W-1:0] m_axis_wr_data_TDATA,
  output logic [KEEP_W-1:0] m_axis_wr_data_TKEEP,
  output logic              m_axis_wr_data_TLAST,
  output logic              m_axis_wr_data_TVALID,
  input  logic              m_axis_wr_data_TREADY,
  output logic [31:0]       drop_count
);

  localparam int OFF_W = $clog2(CHUNK_BYTES);

  state_t              state_q;
  state_t              state_d;
  logic                rdy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic [LEN_W-1:0]    s_len;
  logic [LEN_W:0]      space;
  logic [LEN_W-1:0]    clen;
  logic [LEN_W:0]      beat_sum;
  logic                cmd_acc;
  logic                cmd_fire;
  logic [BEATS_W-1:0]  bcnt;
  desc_t               push_desc;
  desc_t               head;
  logic                full;
  logic                empty;
  logic                d_fire;
  logic                d_last;

  assign s_len   = s_axis_wr_cmd_TDATA[LEN_LSB +: LEN_W];
  assign space   = (LEN_W+1)'(CHUNK_BYTES)
                 - (LEN_W+1)'(addr_q[OFF_W-1:0]);
  assign clen    = ({1'b0, rem_q} < space) ? rem_q
                                           : space[LEN_W-1:0];
  assign beat_sum = (LEN_W+1)'(addr_q[5:0])
                  + {1'b0, clen} + (LEN_W+1)'(63);
  assign push_desc.beats = beat_sum[LEN_W:6];

  assign s_axis_wr_cmd_TREADY = (state_q == IDLE) & rdy_q;
  assign m_axis_wr_cmd_TVALID = (state_q == SPLIT) & ~full;
  assign m_axis_wr_cmd_TDATA  = {clen, addr_q};
  assign cmd_acc  = s_axis_wr_cmd_TVALID & s_axis_wr_cmd_TREADY;
  assign cmd_fire = m_axis_wr_cmd_TVALID & m_axis_wr_cmd_TREADY;

  assign m_axis_wr_data_TVALID = s_axis_wr_data_TVALID & ~empty;
  assign s_axis_wr_data_TREADY = m_axis_wr_data_TREADY & ~empty;
  assign m_axis_wr_data_TDATA  = s_axis_wr_data_TDATA;
  assign m_axis_wr_data_TKEEP  = s_axis_wr_data_TKEEP;
  assign d_last = ~empty & (bcnt == head.beats - 1'b1);
  assign m_axis_wr_data_TLAST  = d_last;
  assign d_fire = s_axis_wr_data_TVALID & m_axis_wr_data_TREADY
                & ~empty;

  // Command FSM state register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state: leave IDLE on a non-empty command,
  // return once the final chunk is handed off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (cmd_acc && s_len != '0) state_d = SPLIT;
      SPLIT:
        if (cmd_fire && rem_q == clen) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/remaining-length walk and drop counting.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rdy_q      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      drop_count <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (cmd_acc) begin
        addr_q <= s_axis_wr_cmd_TDATA[ADDR_LSB +: ADDR_W];
        rem_q  <= s_len;
        if (s_len == '0) drop_count <= drop_count + 1'b1;
      end else if (cmd_fire) begin
        addr_q <= addr_q + ADDR_W'(clen);
        rem_q  <= rem_q - clen;
      end
    end
  end

  // Beat counter within the chunk at the FIFO head.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)   bcnt <= '0;
    else if (d_fire) bcnt <= d_last ? '0 : bcnt + 1'b1;
  end

  sync_desc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (cmd_fire),
    .wdata (push_desc),
    .pop   (d_fire & d_last),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: doc/mem_write_cmd_splitter.md
MEM_WRITE_CMD_SPLITTER -- requirements
Module: mem_write_cmd_splitter

Interface
REQ-001 Parameter CHUNK_BYTES, default 4096: split boundary and maximum output command length in bytes; power of two, at least 64.
REQ-002 Parameter FIFO_DEPTH, default 8: number of chunk descriptors buffered between the command side and the data side.
REQ-003 Port ap_clk, input, 1: single clock for all logic.
REQ-004 Port ap_rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port s_axis_wr_cmd_TDATA/TVALID/TREADY, in/in/out, 96/1/1: write command from the RoCE core; [63:0] byte address, [95:64] byte length.
REQ-006 Port m_axis_wr_cmd_TDATA/TVALID/TREADY, out/out/in, 96/1/1: split commands, same field layout.
REQ-007 Port s_axis_wr_data_TDATA/TKEEP/TVALID/TREADY, in/in/in/out, 512/64/1/1: write payload, address-aligned (byte lane i holds address with addr[5:0]==i).
REQ-008 Port m_axis_wr_data_TDATA/TKEEP/TLAST/TVALID/TREADY, out/out/out/out/in, 512/64/1/1/1: payload, TLAST regenerated per chunk.
REQ-009 Port drop_count, output, 32: count of zero-length commands discarded.

Function
REQ-010 Command FSM has two states, IDLE and SPLIT.
REQ-011 In IDLE, s_axis_wr_cmd_TREADY is 1; a handshake latches addr and rem=len.
  - len==0: drop_count increments, FSM stays in IDLE, nothing is emitted.
  - len!=0: FSM enters SPLIT.
REQ-012 In SPLIT, chunk length clen = min(rem, CHUNK_BYTES - (addr mod CHUNK_BYTES)).
REQ-013 In SPLIT, m_axis_wr_cmd_TVALID is 1 only when the descriptor FIFO is not full; TDATA = {clen, addr}.
REQ-014 On each output command handshake, the block SHALL:
  - push beats = (addr[5:0] + clen + 63) >> 6 into the FIFO;
  - set addr += clen and rem -= clen;
  - return to IDLE when rem becomes 0, otherwise stay in SPLIT.
REQ-015 s_axis_wr_cmd_TREADY is 0 in SPLIT; a new command is accepted no earlier than the cycle after the last chunk handshake.
REQ-016 Latency: the first output command is valid the cycle after input acceptance; while the downstream is ready, one chunk is emitted per cycle.
REQ-017 Address arithmetic is 64-bit modulo 2^64 and length arithmetic is 32-bit; the compare in REQ-012 is done at 33 bits.
REQ-018 Data path is combinational pass-through:
  - m_axis_wr_data_TVALID = s_axis_wr_data_TVALID & fifo_not_empty;
  - s_axis_wr_data_TREADY = m_axis_wr_data_TREADY & fifo_not_empty;
  - TDATA and TKEEP pass unmodified.
REQ-019 Data beat counter bcnt starts at 0.
  - TLAST = (bcnt == head.beats - 1).
  - On each handshake, bcnt increments.
  - On the TLAST handshake, bcnt clears and the FIFO head pops.
REQ-020 Input data TLAST is ignored.
REQ-021 A simultaneous FIFO push and pop in one cycle is legal, including when the FIFO is full (pop first) or empty (no bypass; data waits one cycle).
REQ-022 drop_count wraps from 0xFFFFFFFF to 0.

Reset
REQ-023 While ap_rst_n==0 at a rising edge, the block SHALL:
  - set FSM to IDLE;
  - empty the FIFO;
  - clear bcnt, addr, rem and drop_count.
REQ-024 During and after reset, all outputs SHALL be 0 except s_axis_wr_cmd_TREADY, which is 1 from the first cycle after reset releases.
REQ-025 Reset mid-split discards remaining chunks and in-flight beat counts; partially transferred data is not replayed.

Structure
REQ-026 The shared package holds the command field offsets (ADDR_LSB=0, LEN_LSB=64), CMD_W=96, DATA_W=512, and the descriptor typedef (beats, 27 bits).
REQ-027 The descriptor FIFO is one sub-module, sync_desc_fifo: synchronous, show-ahead, parameterised depth, with full/empty flags.

Verification
REQ-028 Aligned single: cmd addr=0x1000, len=256 -> one cmd {256, 0x1000}; 4 data beats with TLAST on beat 4.
REQ-029 Boundary cross: addr=0x0FC0, len=0x1080 -> three cmds:
  - {0x40, 0x0FC0}, 1 beat;
  - {0x1000, 0x1000}, 64 beats;
  - {0x40, 0x2000}, 1 beat;
  - TLAST on beats 1, 65 and 66.
REQ-030 Unaligned short: addr=0x203C, len=8 -> cmd {8, 0x203C}; beats = (60+8+63)>>6 = 2; TLAST on beat 2.
REQ-031 Zero length: len=0 -> no output cmd; drop_count 0->1; next command accepted the following cycle.
REQ-032 Backpressure: 10 chunks with data TREADY held 0 -> exactly 8 cmds emitted, then cmd TVALID=0; releasing data TREADY resumes cmds; no beat is lost.
REQ-033 Reset mid-split: ap_rst_n=0 after chunk 1 of 3 -> outputs 0; s_axis_wr_cmd_TREADY=1 from the first cycle after reset releases; FIFO empty.
